// File: rtl/hilo_pipe_if.sv
// EX-stage bundle between the pipeline and the HI/LO tracking block.
// The pipeline drives ops and reads the forwarded/architectural values.
interface hilo_pipe_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             flush;
  logic [1:0]       ex_hilo_op;
  logic [WIDTH-1:0] ex_alu_hi;
  logic [WIDTH-1:0] ex_alu_lo;
  logic [WIDTH-1:0] ex_rs_val;
  logic [1:0]       ex_mf_sel;
  logic [WIDTH-1:0] mf_value;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             pending;

  modport master (
    output stall, flush, ex_hilo_op, ex_alu_hi, ex_alu_lo, ex_rs_val, ex_mf_sel,
    input  mf_value, hi_q, lo_q, pending
  );

  modport slave (
    input  stall, flush, ex_hilo_op, ex_alu_hi, ex_alu_lo, ex_rs_val, ex_mf_sel,
    output mf_value, hi_q, lo_q, pending
  );
endinterface

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline: carries mult/div/mthi/mtlo results through M and W,
// commits them to architectural HI/LO and forwards in-flight values to mfhi/mflo.
module hilo_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  hilo_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_MULTDIV = 2'd1,
    OP_MTHI    = 2'd2,
    OP_MTLO    = 2'd3
  } hilo_op_e;

  hilo_op_e ex_op;

  logic             ex_valid, ex_we_hi, ex_we_lo;
  logic [WIDTH-1:0] ex_hi, ex_lo;

  logic             m_valid, m_we_hi, m_we_lo;
  logic [WIDTH-1:0] m_hi, m_lo;
  logic             w_valid, w_we_hi, w_we_lo;
  logic [WIDTH-1:0] w_hi, w_lo;
  logic [WIDTH-1:0] hi_r, lo_r;

  logic [WIDTH-1:0] fwd_hi, fwd_lo;

  assign ex_op = hilo_op_e'(bus.ex_hilo_op);

  // MTHI/MTLO carry rs on both halves; the unused half is masked by its enable.
  always_comb begin
    ex_valid = (ex_op != OP_NONE);
    ex_we_hi = (ex_op == OP_MULTDIV) || (ex_op == OP_MTHI);
    ex_we_lo = (ex_op == OP_MULTDIV) || (ex_op == OP_MTLO);
    ex_hi    = (ex_op == OP_MULTDIV) ? bus.ex_alu_hi : bus.ex_rs_val;
    ex_lo    = (ex_op == OP_MULTDIV) ? bus.ex_alu_lo : bus.ex_rs_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_we_hi <= 1'b0;
      m_we_lo <= 1'b0;
      m_hi    <= '0;
      m_lo    <= '0;
      w_valid <= 1'b0;
      w_we_hi <= 1'b0;
      w_we_lo <= 1'b0;
      w_hi    <= '0;
      w_lo    <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      // W always commits; only the M/W movement depends on flush and stall.
      if (w_valid && w_we_hi) hi_r <= w_hi;
      if (w_valid && w_we_lo) lo_r <= w_lo;

      if (bus.flush || !bus.stall) begin
        w_valid <= m_valid;
        w_we_hi <= m_we_hi;
        w_we_lo <= m_we_lo;
        w_hi    <= m_hi;
        w_lo    <= m_lo;
      end else begin
        w_valid <= 1'b0;
        w_we_hi <= 1'b0;
        w_we_lo <= 1'b0;
        w_hi    <= '0;
        w_lo    <= '0;
      end

      if (bus.flush) begin
        m_valid <= 1'b0;
        m_we_hi <= 1'b0;
        m_we_lo <= 1'b0;
        m_hi    <= '0;
        m_lo    <= '0;
      end else if (!bus.stall) begin
        m_valid <= ex_valid;
        m_we_hi <= ex_we_hi;
        m_we_lo <= ex_we_lo;
        m_hi    <= ex_hi;
        m_lo    <= ex_lo;
      end
    end
  end

  // Each half picks the youngest in-flight writer independently.
  always_comb begin
    fwd_hi = hi_r;
    fwd_lo = lo_r;
    if (m_valid && m_we_hi)      fwd_hi = m_hi;
    else if (w_valid && w_we_hi) fwd_hi = w_hi;
    if (m_valid && m_we_lo)      fwd_lo = m_lo;
    else if (w_valid && w_we_lo) fwd_lo = w_lo;

    case (bus.ex_mf_sel)
      2'd1:    bus.mf_value = fwd_hi;
      2'd2:    bus.mf_value = fwd_lo;
      default: bus.mf_value = '0;
    endcase
  end

  assign bus.hi_q    = hi_r;
  assign bus.lo_q    = lo_r;
  assign bus.pending = (m_valid && (m_we_hi || m_we_lo)) ||
                       (w_valid && (w_we_hi || w_we_lo));

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed bench for hilo_pipe: hand-computed forwarding, commit latency,
// stall, flush and asynchronous reset cases.
module tb_hilo_pipe;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  hilo_pipe_if #(.WIDTH(WIDTH)) bus ();

  hilo_pipe #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Consumes one rising edge, then drives the inputs for the new cycle and
  // parks at the falling edge so outputs can be sampled mid-cycle.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a_hi,
                               input logic [WIDTH-1:0] a_lo, input logic [WIDTH-1:0] rs,
                               input logic [1:0] mf, input logic st, input logic fl);
    @(posedge clk);
    #1;
    bus.ex_hilo_op = op;
    bus.ex_alu_hi  = a_hi;
    bus.ex_alu_lo  = a_lo;
    bus.ex_rs_val  = rs;
    bus.ex_mf_sel  = mf;
    bus.stall      = st;
    bus.flush      = fl;
    @(negedge clk);
  endtask

  task automatic idleRead(input logic [1:0] mf, input logic st);
    applyStimulus(2'd0, '0, '0, '0, mf, st, 1'b0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n          = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.ex_hilo_op = 2'd0;
    bus.ex_alu_hi  = '0;
    bus.ex_alu_lo  = '0;
    bus.ex_rs_val  = '0;
    bus.ex_mf_sel  = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    idleRead(2'd1, 1'b0);
    checkOutput("rst_mfhi", bus.mf_value, 32'h0);
    checkOutput("rst_hi_q", bus.hi_q, 32'h0);
    checkOutput("rst_lo_q", bus.lo_q, 32'h0);
    checkOutput("rst_pending", {31'b0, bus.pending}, 32'h0);
    idleRead(2'd2, 1'b0);
    checkOutput("rst_mflo", bus.mf_value, 32'h0);

    // MULTDIV then MFLO forwarded from M, W, then architectural
    applyStimulus(2'd1, 32'h0000_0001, 32'hFFFF_FFFE, '0, 2'd0, 1'b0, 1'b0);
    checkOutput("md_pending_c0", {31'b0, bus.pending}, 32'h0);
    idleRead(2'd2, 1'b0);
    checkOutput("md_mflo_c1", bus.mf_value, 32'hFFFF_FFFE);
    checkOutput("md_pending_c1", {31'b0, bus.pending}, 32'h1);
    checkOutput("md_hi_q_c1", bus.hi_q, 32'h0);
    idleRead(2'd2, 1'b0);
    checkOutput("md_mflo_c2", bus.mf_value, 32'hFFFF_FFFE);
    checkOutput("md_pending_c2", {31'b0, bus.pending}, 32'h1);
    checkOutput("md_hi_q_c2", bus.hi_q, 32'h0);
    idleRead(2'd2, 1'b0);
    checkOutput("md_mflo_c3", bus.mf_value, 32'hFFFF_FFFE);
    checkOutput("md_hi_q_c3", bus.hi_q, 32'h1);
    checkOutput("md_lo_q_c3", bus.lo_q, 32'hFFFF_FFFE);
    checkOutput("md_pending_c3", {31'b0, bus.pending}, 32'h0);

    // MTHI then MTLO, read both halves while they sit in W and M
    applyStimulus(2'd2, '0, '0, 32'hAAAA_0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'd3, '0, '0, 32'h0000_5555, 2'd0, 1'b0, 1'b0);
    idleRead(2'd1, 1'b0);
    checkOutput("mt_mfhi_from_w", bus.mf_value, 32'hAAAA_0000);
    bus.ex_mf_sel = 2'd2;
    #1;
    checkOutput("mt_mflo_from_m", bus.mf_value, 32'h0000_5555);
    bus.ex_mf_sel = 2'd3;
    #1;
    checkOutput("mf_reserved", bus.mf_value, 32'h0);
    idleRead(2'd0, 1'b0);
    idleRead(2'd0, 1'b0);
    checkOutput("mt_hi_q", bus.hi_q, 32'hAAAA_0000);
    checkOutput("mt_lo_q", bus.lo_q, 32'h0000_5555);

    // Partial overlap: MULTDIV in W, MTHI in M
    applyStimulus(2'd1, 32'h0000_0011, 32'h0000_0022, '0, 2'd0, 1'b0, 1'b0);
    applyStimulus(2'd2, '0, '0, 32'h0000_0033, 2'd0, 1'b0, 1'b0);
    idleRead(2'd1, 1'b0);
    checkOutput("part_mfhi_m", bus.mf_value, 32'h0000_0033);
    bus.ex_mf_sel = 2'd2;
    #1;
    checkOutput("part_mflo_w", bus.mf_value, 32'h0000_0022);
    idleRead(2'd0, 1'b0);
    idleRead(2'd0, 1'b0);
    checkOutput("part_hi_q", bus.hi_q, 32'h0000_0033);
    checkOutput("part_lo_q", bus.lo_q, 32'h0000_0022);

    // MULTDIV hi=7 held in M by a 3-cycle stall
    applyStimulus(2'd1, 32'h0000_0007, 32'h0000_0008, '0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idleRead(2'd1, 1'b1);
      checkOutput($sformatf("stall_mfhi_%0d", i), bus.mf_value, 32'h0000_0007);
      checkOutput($sformatf("stall_hi_q_%0d", i), bus.hi_q, 32'h0000_0033);
      checkOutput($sformatf("stall_pending_%0d", i), {31'b0, bus.pending}, 32'h1);
    end
    idleRead(2'd0, 1'b0);
    checkOutput("stall_rel_hi_q0", bus.hi_q, 32'h0000_0033);
    idleRead(2'd0, 1'b0);
    checkOutput("stall_rel_hi_q1", bus.hi_q, 32'h0000_0033);
    idleRead(2'd0, 1'b0);
    checkOutput("stall_commit_hi_q", bus.hi_q, 32'h0000_0007);
    checkOutput("stall_commit_lo_q", bus.lo_q, 32'h0000_0008);

    // MTLO squashed by flush in the same cycle
    applyStimulus(2'd3, '0, '0, 32'h0000_1234, 2'd0, 1'b0, 1'b1);
    idleRead(2'd2, 1'b0);
    checkOutput("flush_pending", {31'b0, bus.pending}, 32'h0);
    checkOutput("flush_mflo", bus.mf_value, 32'h0000_0008);
    idleRead(2'd0, 1'b0);
    idleRead(2'd0, 1'b0);
    checkOutput("flush_lo_q", bus.lo_q, 32'h0000_0008);

    // Async reset while MULTDIV sits in W
    applyStimulus(2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, '0, 2'd0, 1'b0, 1'b0);
    idleRead(2'd0, 1'b0);
    idleRead(2'd1, 1'b0);
    checkOutput("arst_pre_pending", {31'b0, bus.pending}, 32'h1);
    checkOutput("arst_pre_mfhi", bus.mf_value, 32'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_hi_q", bus.hi_q, 32'h0);
    checkOutput("arst_lo_q", bus.lo_q, 32'h0);
    checkOutput("arst_pending", {31'b0, bus.pending}, 32'h0);
    #1 rst_n = 1'b1;
    idleRead(2'd1, 1'b0);
    idleRead(2'd1, 1'b0);
    checkOutput("arst_lost_hi_q", bus.hi_q, 32'h0);
    checkOutput("arst_lost_lo_q", bus.lo_q, 32'h0);
    checkOutput("arst_lost_mfhi", bus.mf_value, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hilo_pipe.md
Name: hilo_pipe

Overview:
- Execute-stage consumer of the ALU's hi/lo outputs.
- Carries mult/div/mthi/mtlo results through two pipeline slots, M (EX/MEM) and W (MEM/WB), then commits them to the architectural HI/LO registers.
- Serves mfhi/mflo reads issued in EX with full forwarding from in-flight slots, so no software hazard gap is needed.

Parameters:
- WIDTH, 32, data width of HI, LO and all data ports.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall from hazard unit; freezes EX->M capture.
- flush  in  1  squash the instruction currently in EX.
- ex_hilo_op  in  2  op in EX: 0 NONE, 1 MULTDIV (write both), 2 MTHI, 3 MTLO.
- ex_alu_hi  in  WIDTH  ALU hi output (MULTDIV).
- ex_alu_lo  in  WIDTH  ALU lo output (MULTDIV).
- ex_rs_val  in  WIDTH  forwarded rs operand (MTHI/MTLO source).
- ex_mf_sel  in  2  read in EX: 0 none, 1 MFHI, 2 MFLO, 3 reserved (treated as none).
- mf_value  out  WIDTH  forwarded HI or LO value for the EX read (combinational).
- hi_q  out  WIDTH  architectural HI.
- lo_q  out  WIDTH  architectural LO.
- pending  out  1  any valid write in M or W.

Behaviour:
- Slot contents: each of M and W holds valid, we_hi, we_lo, hi_d and lo_d.
  - MULTDIV: we_hi=we_lo=1, hi_d=ex_alu_hi, lo_d=ex_alu_lo.
  - MTHI: we_hi=1, hi_d=ex_rs_val.
  - MTLO: we_lo=1, lo_d=ex_rs_val.
  - NONE: valid=0.
- Reset (rst_n low, asynchronous): M and W invalid with all enables 0; hi_q=lo_q=0; pending=0. Reset asserted mid-operation discards all in-flight writes immediately.
- Normal edge (stall=0, flush=0): M <= EX op; W <= M; if W valid, commit hi_q<=hi_d when we_hi and lo_q<=lo_d when we_lo.
- Latency: op in EX during cycle N is in M in N+1, in W in N+2, and visible on hi_q/lo_q from N+3.
- Stall=1, flush=0:
  - M holds its contents.
  - W <= bubble.
  - W still commits its current contents.
  - Ordering is preserved because M is younger than W.
- Flush=1 (priority over stall): M <= bubble (EX op squashed); W <= M; W commits as normal.
- Forwarding for mf_value, per half (HI and LO independently), youngest first:
  1. M if valid and the matching enable is set.
  2. Else W if valid and the matching enable is set.
  3. Else hi_q/lo_q.
- Partial ops: MTHI in M followed by MULTDIV in W means MFHI returns the M value, while MFLO returns the W lo_d.
- mf_value=0 when ex_mf_sel is 0 or 3.
- mf_value reflects the state before the edge, so a same-cycle op in EX is not visible to a read in EX. The hazard unit guarantees mf and hilo ops never share an instruction.
- pending = (M.valid & (M.we_hi|M.we_lo)) | (W.valid & (W.we_hi|W.we_lo)).
- Widths: no arithmetic in this block; all data is passed through at WIDTH bits with no sign or width changes.

Test Plan:
- Reset, then MFHI and MFLO: mf_value=0, hi_q=lo_q=0, pending=0.
- MULTDIV hi=0x00000001, lo=0xFFFFFFFE in cycle 0, then MFLO in cycles 1, 2 and 3:
  - mf_value=0xFFFFFFFE each cycle (forwarded from M, then W, then architectural).
  - hi_q=1 from cycle 3.
  - pending high in cycles 1-2.
- MTHI 0xAAAA0000 in cycle 0, MTLO 0x5555 in cycle 1, MFHI and MFLO in cycle 2:
  - MFHI returns 0xAAAA0000 (from W); MFLO returns 0x5555 (from M).
  - After drain: hi_q=0xAAAA0000, lo_q=0x5555.
- MULTDIV hi=7 with stall held 3 cycles after capture:
  - M holds; W bubbles; hi_q is unchanged until the stall drops.
  - MFHI during the stall returns 7.
  - Commit occurs 2 edges after the stall releases.
- MTLO 0x1234 with flush=1 in the same cycle: never committed; lo_q keeps its previous value; pending=0.
- MULTDIV hi=lo=0xDEADBEEF, then rst_n pulsed low asynchronously mid-cycle while the op is in W: hi_q=lo_q=0 immediately; the write is lost.
